// File: rtl/antitheft_ctrl_mc.sv
// Multi-door anti-theft controller with an integrated delay timer,
// run-time programmable delays, trigger-door reporting and a
// saturating alarm counter.
module antitheft_ctrl_mc #(
  parameter int N_DOORS    = 4,
  parameter int DRIVER_IDX = 0,
  parameter int W          = 4,
  parameter int T_ARM      = 6,
  parameter int T_DRIVER   = 8,
  parameter int T_PASS     = 15,
  parameter int T_ALARM    = 10,
  localparam int TW        = $clog2(N_DOORS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] doors,
  input  logic               prog_en,
  input  logic [1:0]         prog_sel,
  input  logic [W-1:0]       prog_val,
  output logic [2:0]         state,
  output logic               siren,
  output logic               status,
  output logic [W-1:0]       countdown,
  output logic [TW-1:0]      trig_door,
  output logic [3:0]         alarm_count
);

  typedef enum logic [2:0] {
    S_ARMED      = 3'd0,
    S_TRIGGERED  = 3'd1,
    S_ALARM      = 3'd2,
    S_IGN_ON     = 3'd3,
    S_WAIT_OPEN  = 3'd4,
    S_WAIT_CLOSE = 3'd5,
    S_ARM_DELAY  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d, cnt_tick;
  logic [TW-1:0] trig_q, trig_d, trig_pick;
  logic [3:0]    acnt_q, acnt_d;
  logic          status_q, status_d;
  logic [W-1:0]  arm_dly, drv_dly, pass_dly, alarm_dly;
  logic          any_open, drv_open, prog_ok;

  assign any_open = |doors;
  assign drv_open = doors[DRIVER_IDX];
  assign prog_ok  = (state_q == S_IGN_ON) || (state_q == S_WAIT_OPEN) ||
                    (state_q == S_WAIT_CLOSE);
  assign cnt_tick = (one_hz_enable && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

  // Trigger door: driver door wins, otherwise the lowest-index open door.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    trig_pick = '0;
    for (int i = N_DOORS - 1; i >= 0; i--) begin
      if (doors[i]) trig_pick = TW'(i);
    end
    if (drv_open) trig_pick = TW'(DRIVER_IDX);
  end

  // Next-state, timer load/decrement, trigger latch and alarm count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    trig_d  = trig_q;
    acnt_d  = acnt_q;
    if (ignition && state_q != S_IGN_ON) begin
      state_d = S_IGN_ON;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (any_open) begin
            state_d = S_TRIGGERED;
            cnt_d   = drv_open ? drv_dly : pass_dly;
            trig_d  = trig_pick;
          end
        end
        S_TRIGGERED: begin
          if (cnt_q == '0) begin
            state_d = S_ALARM;
            cnt_d   = alarm_dly;
            if (acnt_q != 4'd15) acnt_d = acnt_q + 4'd1;
          end else begin
            cnt_d = cnt_tick;
          end
        end
        S_ALARM: begin
          if (cnt_q == '0) state_d = S_ARMED;
          else             cnt_d   = cnt_tick;
        end
        S_IGN_ON: begin
          if (!ignition) state_d = S_WAIT_OPEN;
        end
        S_WAIT_OPEN: begin
          if (drv_open) state_d = S_WAIT_CLOSE;
        end
        S_WAIT_CLOSE: begin
          if (!drv_open) begin
            state_d = S_ARM_DELAY;
            cnt_d   = arm_dly;
          end
        end
        S_ARM_DELAY: begin
          if (any_open)            cnt_d   = arm_dly;
          else if (cnt_q == '0)    state_d = S_ARMED;
          else                     cnt_d   = cnt_tick;
        end
        default: state_d = S_ARMED;
      endcase
    end
  end

  // Status LED follows the state being entered; blinks while armed.
  always_comb begin
    status_d = 1'b0;
    case (state_d)
      S_ARMED:                status_d = (state_q == S_ARMED) ? (status_q ^ one_hz_enable) : 1'b0;
      S_TRIGGERED, S_ALARM:   status_d = 1'b1;
      default:                status_d = 1'b0;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_ARMED;
      cnt_q    <= '0;
      trig_q   <= '0;
      acnt_q   <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      acnt_q   <= acnt_d;
      status_q <= status_d;
    end
  end

  // Delay registers; writable only while disarmed. A load in the same
  // cycle still sees the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      arm_dly   <= W'(T_ARM);
      drv_dly   <= W'(T_DRIVER);
      pass_dly  <= W'(T_PASS);
      alarm_dly <= W'(T_ALARM);
    end else if (prog_en && prog_ok) begin
      case (prog_sel)
        2'd0:    arm_dly   <= prog_val;
        2'd1:    drv_dly   <= prog_val;
        2'd2:    pass_dly  <= prog_val;
        default: alarm_dly <= prog_val;
      endcase
    end
  end

  assign state       = state_q;
  assign siren       = (state_q == S_ALARM);
  assign status      = status_q;
  assign countdown   = cnt_q;
  assign trig_door   = trig_q;
  assign alarm_count = acnt_q;

endmodule

// File: tb/tb_antitheft_ctrl_mc.sv
// Directed self-checking bench for antitheft_ctrl_mc (default parameters).
module tb_antitheft_ctrl_mc;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_hz_enable;
  logic       ignition;
  logic [3:0] doors;
  logic       prog_en;
  logic [1:0] prog_sel;
  logic [3:0] prog_val;
  logic [2:0] state;
  logic       siren;
  logic       status;
  logic [3:0] countdown;
  logic [1:0] trig_door;
  logic [3:0] alarm_count;

  int checks   = 0;
  int failures = 0;

  antitheft_ctrl_mc dut (
    .clock         (clock),
    .reset         (reset),
    .one_hz_enable (one_hz_enable),
    .ignition      (ignition),
    .doors         (doors),
    .prog_en       (prog_en),
    .prog_sel      (prog_sel),
    .prog_val      (prog_val),
    .state         (state),
    .siren         (siren),
    .status        (status),
    .countdown     (countdown),
    .trig_door     (trig_door),
    .alarm_count   (alarm_count)
  );

  always #5 clock = ~clock;

  // One clock edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      one_hz_enable = 1'b1;
      step();
      one_hz_enable = 1'b0;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    prog_en  = 1'b1;
    prog_sel = sel;
    prog_val = val;
    step();
    prog_en  = 1'b0;
  endtask

  // From IGN_ON with ignition still high: walk the disarm sequence to ARM_DELAY.
  task automatic disarm_to_arm_delay();
    ignition = 1'b0; step();
    doors = 4'b0001; step();
    doors = 4'b0000; step();
  endtask

  initial begin
    reset = 1'b1; one_hz_enable = 1'b0; ignition = 1'b0; doors = '0;
    prog_en = 1'b0; prog_sel = '0; prog_val = '0;
    step(); step();
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_countdown", countdown, 0);
    check("rst_status", status, 0);
    check("rst_siren", siren, 0);
    check("rst_trig", trig_door, 0);
    check("rst_acount", alarm_count, 0);

    // Passenger door 2 triggers, full alarm cycle.
    doors = 4'b0100; step(); doors = '0;
    check("trig_state", state, 1);
    check("trig_cd", countdown, 15);
    check("trig_door2", trig_door, 2);
    check("trig_status", status, 1);
    pulses(15);
    check("trig_expired_cd", countdown, 0);
    check("trig_still", state, 1);
    step();
    check("alarm_state", state, 2);
    check("alarm_siren", siren, 1);
    check("alarm_cd", countdown, 10);
    check("alarm_count1", alarm_count, 1);
    pulses(10);
    check("alarm_hold", state, 2);
    step();
    check("rearm_state", state, 0);
    check("rearm_siren", siren, 0);
    check("rearm_status", status, 0);
    pulses(1);
    check("armed_blink", status, 1);

    // Two doors at once: driver wins, driver delay.
    doors = 4'b0101; step(); doors = '0;
    check("multi_trig_door", trig_door, 0);
    check("multi_cd", countdown, 8);
    ignition = 1'b1; step();
    check("ign_from_trig", state, 3);
    check("ign_cd_zero", countdown, 0);
    check("ign_status", status, 0);

    // Disarm sequence and arm-delay reload.
    ignition = 1'b0; step();
    check("wait_open", state, 4);
    doors = 4'b0001; step();
    check("wait_close", state, 5);
    doors = 4'b0000; step();
    check("arm_delay", state, 6);
    check("arm_delay_cd", countdown, 6);
    pulses(3);
    check("arm_delay_cd3", countdown, 3);
    doors = 4'b0010; step();
    check("arm_reload_cd", countdown, 6);
    check("arm_reload_state", state, 6);
    doors = 4'b0000; step();
    pulses(6);
    check("arm_delay_exp", state, 6);
    step();
    check("armed_after_delay", state, 0);

    // Program alarm = 2 in IGN_ON; arm = 3 written in the same cycle as
    // the arm-delay load (old value used); ARMED-state write ignored.
    ignition = 1'b1; step();
    prog(2'd3, 4'd2);
    ignition = 1'b0; step();
    doors = 4'b0001; step();
    doors = 4'b0000; prog_en = 1'b1; prog_sel = 2'd0; prog_val = 4'd3; step();
    prog_en = 1'b0;
    check("load_uses_old", countdown, 6);
    pulses(6); step();
    check("armed_again", state, 0);
    prog(2'd3, 4'd9);
    check("prog_armed_state", state, 0);
    doors = 4'b1000; step(); doors = '0;
    check("pass_trig_door3", trig_door, 3);
    pulses(15); step();
    check("short_alarm_cd", countdown, 2);
    check("acount2", alarm_count, 2);
    pulses(2);
    check("short_alarm_siren", siren, 1);
    step();
    check("short_alarm_end", siren, 0);

    // Alarm = 10, driver = 0; new arm delay 3 now in use.
    ignition = 1'b1; step();
    prog(2'd3, 4'd10);
    prog(2'd1, 4'd0);
    disarm_to_arm_delay();
    check("new_arm_cd", countdown, 3);
    pulses(3); step();
    doors = 4'b0001; step(); doors = '0;
    check("zero_delay_trig", state, 1);
    check("zero_delay_cd", countdown, 0);
    step();
    check("zero_delay_exp", state, 2);
    check("acount3", alarm_count, 3);
    pulses(6);
    check("alarm_cd4", countdown, 4);
    ignition = 1'b1; step();
    check("ign_in_alarm", state, 3);
    check("ign_siren_off", siren, 0);

    // Reset during alarm.
    disarm_to_arm_delay();
    pulses(3); step();
    doors = 4'b0001; step(); doors = '0; step();
    check("pre_reset_alarm", state, 2);
    pulses(2);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_siren", siren, 0);
    check("mid_rst_cd", countdown, 0);
    check("mid_rst_acount", alarm_count, 0);

    // Door plus ignition together in ARMED: IGN_ON, trig_door untouched.
    doors = 4'b0100; ignition = 1'b1; step(); doors = '0;
    check("door_ign_state", state, 3);
    check("door_ign_trig", trig_door, 0);

    // Zero delays everywhere, then 16 quick alarms.
    prog(2'd1, 4'd0);
    prog(2'd3, 4'd0);
    prog(2'd0, 4'd0);
    disarm_to_arm_delay();
    step();
    check("quick_armed", state, 0);
    for (int i = 0; i < 16; i++) begin
      doors = 4'b0001; step(); doors = '0;
      step(); step();
      if (i == 14) check("acount15", alarm_count, 15);
    end
    check("acount_sat", alarm_count, 15);
    check("final_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
